// File: rtl/uart_rx_oversample.sv
// UART receiver with majority-vote oversampling and a one-entry holding register.
// Optional even-parity bit is enabled by defining UART_RX_PARITY_EN (default build is 8N1).
module uart_rx_oversample #(
  parameter int OS_RATE   = 16,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 os_tick,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CW = $clog2(OS_RATE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] C_S0   = CW'(OS_RATE/2 - 1);
  localparam logic [CW-1:0] C_S1   = CW'(OS_RATE/2);
  localparam logic [CW-1:0] C_DEC  = CW'(OS_RATE/2 + 1);
  localparam logic [CW-1:0] C_LAST = CW'(OS_RATE - 1);
  localparam logic [BW-1:0] C_BLAST = BW'(DATA_BITS - 1);

  // state     | meaning
  // S_IDLE    | line idle, waiting for a low sample on os_tick
  // S_START   | validating the start bit
  // S_DATA    | shifting data bits, LSB first
  // S_PARITY  | sampling the even-parity bit (parity builds only)
  // S_STOP    | checking the stop bit
  // S_WAIT_HIGH | after a framing error, waiting for the line to return high
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
`ifdef UART_RX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  logic                 r_sync1, r_sync2;
  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bitcnt;
  logic                 r_samp0, r_samp1;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_done;
  logic                 r_frame_err;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_overrun;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_new;
  logic                 r_perr;
`endif

  logic w_rx, w_dec, w_wrap, w_maj;

  assign w_rx   = r_sync2;
  assign w_dec  = os_tick && (r_cnt == C_DEC);
  assign w_wrap = os_tick && (r_cnt == C_LAST);
  assign w_maj  = (r_samp0 & r_samp1) | (r_samp0 & w_rx) | (r_samp1 & w_rx);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_serial;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bitcnt    <= '0;
      r_samp0     <= 1'b1;
      r_samp1     <= 1'b1;
      r_shift     <= '0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_new   <= 1'b0;
`endif
    end else begin
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
      if (os_tick && (r_cnt == C_S0)) r_samp0 <= w_rx;
      if (os_tick && (r_cnt == C_S1)) r_samp1 <= w_rx;
      case (r_state)
        S_IDLE: begin
          if (os_tick && !w_rx) begin
            r_state <= S_START;
            r_cnt   <= '0;
          end
        end
        S_START: begin
          if (w_dec && w_maj) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (w_wrap) begin
            r_state  <= S_DATA;
            r_cnt    <= '0;
            r_bitcnt <= '0;
          end else if (os_tick) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_dec) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
          if (w_wrap) begin
            r_cnt <= '0;
            if (r_bitcnt == C_BLAST) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end else if (os_tick) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_dec) r_par_new <= (^r_shift) ^ w_maj;
          if (w_wrap) begin
            r_state <= S_STOP;
            r_cnt   <= '0;
          end else if (os_tick) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`endif
        // Stop is decided mid-bit so a back-to-back start edge is never missed.
        S_STOP: begin
          if (w_dec) begin
            r_cnt <= '0;
            if (w_maj) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= S_WAIT_HIGH;
              r_frame_err <= 1'b1;
            end
          end else if (os_tick) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          if (os_tick && w_rx) r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr    <= 1'b0;
`endif
    end else begin
      r_overrun <= 1'b0;
      if (r_done) begin
        if (!r_valid || rx_ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
          r_perr  <= r_par_new;
`endif
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample: frame-level model of expected deliveries,
// frame errors and overruns, checked by one per-cycle compare process.
module tb_uart_rx_oversample;
  localparam int OS       = 16;
  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = OS * TICK_DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       os_tick;
  logic       rx_serial;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  int tests = 0;
  int fails = 0;

  // expected deliveries: {parity_err, data}
  logic [8:0] exp_q[$];
  logic [8:0] cur_exp = '0;
  logic       m_held = 1'b0;
  int         exp_fe = 0;
  int         exp_ov = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         n_loads = 0;
  logic [7:0] last_cons = '0;
  logic       last_cons_perr = 1'b0;
  logic       prev_v = 1'b0;
  logic       prev_vr = 1'b0;

  always #5 clk = ~clk;

  uart_rx_oversample #(.OS_RATE(OS), .DATA_BITS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .os_tick    (os_tick),
    .rx_serial  (rx_serial),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    os_tick = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(negedge clk);
      os_tick = 1'b1;
      @(negedge clk);
      os_tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rx_valid) begin
      if (!prev_v || prev_vr) begin
        n_loads++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid: got data 0x%0h with no byte expected", rx_data);
        end else begin
          cur_exp = exp_q.pop_front();
        end
      end
      check("held_data", {24'd0, rx_data}, {24'd0, cur_exp[7:0]});
      check("held_perr", {31'd0, parity_err}, {31'd0, cur_exp[8]});
      if (rx_ready) begin
        last_cons      = rx_data;
        last_cons_perr = parity_err;
      end
    end
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    prev_v  = rx_valid;
    prev_vr = rx_valid && rx_ready;
  end

  task automatic send_bit(input logic b);
    rx_serial = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic idle_bits(input int n);
    rx_serial = 1'b1;
    repeat (n * BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    logic pe;
`ifdef UART_RX_PARITY_EN
    pe = (^d) ^ par;
`else
    pe = 1'b0;
`endif
    if (!stop) exp_fe++;
    else if (m_held && !rx_ready) exp_ov++;
    else begin
      exp_q.push_back({pe, d});
      if (!rx_ready) m_held = 1'b1;
    end
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`endif
    send_bit(stop);
  endtask

  initial begin
    rst       = 1'b1;
    rx_serial = 1'b1;
    rx_ready  = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_data", {24'd0, rx_data}, 32'd0);
    check("rst_perr", {31'd0, parity_err}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    rst = 1'b0;
    idle_bits(2);

    // 0x55 8N1, always ready
    send_frame(8'h55, 1'b0, 1'b1);
    idle_bits(1);
    check("r030_data", {24'd0, last_cons}, 32'h55);
    check("r030_perr", {31'd0, last_cons_perr}, 32'd0);
    check("r030_ferr", fe_cnt, 32'd0);
    check("r030_loads", n_loads, 32'd1);
    check("r030_valid_clear", {31'd0, rx_valid}, 32'd0);

    // 3-tick low glitch: false start
    rx_serial = 1'b0;
    repeat (3 * TICK_DIV) @(negedge clk);
    idle_bits(2);
    check("r031_loads", n_loads, 32'd1);
    check("r031_valid", {31'd0, rx_valid}, 32'd0);

    // bad stop bit followed by a 40-bit break
    send_frame(8'hA3, 1'b0, 1'b0);
    rx_serial = 1'b0;
    repeat (40 * BIT_CLKS) @(negedge clk);
    idle_bits(2);
    check("r032_ferr_cnt", fe_cnt, 32'd1);
    check("r032_loads", n_loads, 32'd1);
    send_frame(8'h12, 1'b0, 1'b1);
    idle_bits(1);
    check("r032_next_data", {24'd0, last_cons}, 32'h12);

    // back-to-back with consumer stalled
    rx_ready = 1'b0;
    send_frame(8'h01, 1'b0, 1'b1);
    send_frame(8'h02, 1'b0, 1'b1);
    idle_bits(2);
    check("r033_ovr_cnt", ov_cnt, 32'd1);
    check("r033_valid", {31'd0, rx_valid}, 32'd1);
    check("r033_data", {24'd0, rx_data}, 32'h01);
    rx_ready = 1'b1;
    m_held   = 1'b0;
    repeat (4) @(negedge clk);
    check("r033_consumed", {24'd0, last_cons}, 32'h01);
    check("r033_valid_clear", {31'd0, rx_valid}, 32'd0);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b0, 1'b1);
    idle_bits(1);
    check("r034_data0", {24'd0, last_cons}, 32'h07);
    check("r034_perr0", {31'd0, last_cons_perr}, 32'd1);
    send_frame(8'h07, 1'b1, 1'b1);
    idle_bits(1);
    check("r034_data1", {24'd0, last_cons}, 32'h07);
    check("r034_perr1", {31'd0, last_cons_perr}, 32'd0);
`endif

    // reset in the middle of the 4th data bit of 0xFF
    begin
      int loads_before;
      loads_before = n_loads;
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      rx_serial = 1'b1;
      repeat (BIT_CLKS / 2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (BIT_CLKS / 2) @(negedge clk);
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      idle_bits(2);
      check("r035_loads", n_loads, loads_before);
      check("r035_data_rst", {24'd0, rx_data}, 32'd0);
      check("r035_valid", {31'd0, rx_valid}, 32'd0);
    end
    send_frame(8'h3C, 1'b0, 1'b1);
    idle_bits(2);
    check("r035_next_data", {24'd0, last_cons}, 32'h3C);

    check("end_pending", exp_q.size(), 32'd0);
    check("end_ferr", fe_cnt, exp_fe);
    check("end_ovr", ov_cnt, exp_ov);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
